// File: rtl/move_replayer.sv
// move_replayer: pops moves off a stack and replays their inverses as paced steps.
// Build option MOVE_REPLAY_PACE_EN inserts a STEP_DELAY-cycle PACE state after each accepted step.
module move_replayer #(
  parameter int W = 3,
  parameter int CW = 6,
  parameter int STEP_DELAY = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic          Abort,
  input  logic          StackEmpty,
  input  logic [W-1:0]  MoveIn,
  output logic          PopReq,
  output logic [W-1:0]  StepOut,
  output logic          StepValid,
  input  logic          StepAck,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] StepCount
);
  if (STEP_DELAY < 1 || STEP_DELAY > 255) begin : g_bad_delay
    $error("STEP_DELAY must be in 1..255");
  end
  typedef enum logic [2:0] {
    IDLE, POP, WAIT, OFFER,
`ifdef MOVE_REPLAY_PACE_EN
    PACE,
`endif
    DONE
  } state_t;
  state_t st, nxt, after_step;
  logic [W-1:0] stp, inv;
  logic valid;
`ifdef MOVE_REPLAY_PACE_EN
  logic [7:0] pc;
`endif
  // N<->S and E<->W; codes 0 and 5..7 are skipped
  assign valid = (MoveIn != '0) && (MoveIn <= W'(4));
  assign inv = MoveIn == W'(1) ? W'(3) : MoveIn == W'(2) ? W'(4) : MoveIn == W'(3) ? W'(1) : W'(2);
  assign after_step = StackEmpty ? DONE : POP;
  assign PopReq = st == POP;
  assign StepValid = st == OFFER;
  assign StepOut = st == OFFER ? stp : '0;
  assign Busy = st != IDLE;
  assign Done = st == DONE;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:  nxt = Start ? after_step : IDLE;
      POP:   nxt = WAIT;
      WAIT:  nxt = valid ? OFFER : after_step;
`ifdef MOVE_REPLAY_PACE_EN
      OFFER: nxt = StepAck ? PACE : OFFER;
      PACE:  nxt = pc == 8'(STEP_DELAY - 1) ? after_step : PACE;
`else
      OFFER: nxt = StepAck ? after_step : OFFER;
`endif
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (Abort && st != IDLE) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      stp <= '0;
      StepCount <= '0;
`ifdef MOVE_REPLAY_PACE_EN
      pc <= '0;
`endif
    end else begin
      st <= nxt;
      if (st == WAIT) stp <= inv;
      if (st == IDLE && Start) StepCount <= '0;
      else if (st == OFFER && StepAck && !Abort && StepCount != '1) StepCount <= StepCount + 1'b1;
`ifdef MOVE_REPLAY_PACE_EN
      pc <= (st == PACE && nxt == PACE) ? pc + 8'd1 : 8'd0;
`endif
    end
  end
endmodule
